ram_controller: RTL and testbench
=================================

# ram_controller

Sequencer that fills a 256-entry x 8-bit RAM (the RC4 state array S) with a mode-selected pattern, one write per clock. It sits between the top-level decryption FSM and the on-chip RAM's write port. It drives address, write data and write enable, and reports completion over a start/finished level handshake.

## Interface
Parameters: none (depth fixed at 256, data width fixed at 8).

- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  input  1  level request; sampled only in IDLE.
- mode  input  3  fill pattern select; latched when a request is accepted.
- address  output  8  RAM address.
- ram_in  output  8  RAM write data.
- wrenbus  output  1  RAM write enable.
- finished_bus  output  1  operation-complete flag.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - All outputs are 0.
  - When start=1 is sampled: latch mode into mode_q, clear the index counter, go to WRITE.
- WRITE:
  - Each cycle: address=i, ram_in=pattern(mode_q,i), wrenbus=1, then i increments.
  - After i=255 is presented, go to DONE.
  - start and mode are ignored in WRITE; a run always completes all 256 writes.
- DONE:
  - finished_bus=1, wrenbus=0; address and ram_in hold their last values (255 and its pattern).
  - Stay in DONE while start=1.
  - When start=0 is sampled, go to IDLE and clear finished_bus.
- Patterns, with i as an 8-bit unsigned index:
  - 001: i (RC4 init).
  - 010: 8'h00.
  - 011: 8'hFF.
  - 100: 8'd255 - i.
- Modes 000, 101, 110, 111 are no-ops: on acceptance, go straight to DONE with no writes.
- The index counter is 8 bits and reaches exactly 255. There is no wrap write and no write to any address above 255.

## Timing
- Reset, sampled at a rising edge, has priority over every other input.
  - Next state: IDLE.
  - address=0, ram_in=0, wrenbus=0, finished_bus=0, i=0, mode_q=0.
- A reset asserted mid-WRITE aborts the run immediately. No further writes are issued; partially written RAM is left as-is.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency:
  - If start is sampled high at edge N, the first write (address 0) is presented from edge N+1.
  - Writes for addresses 0..255 occupy 256 consecutive cycles.
  - finished_bus rises at edge N+257, the same edge at which wrenbus falls.
- No-op mode: finished_bus rises at edge N+1.
- Handshake:
  - finished_bus falls one cycle after start is sampled low in DONE.
  - A new request needs start to be low for at least one sampled edge, then high again.
  - A start low pulse of a single cycle is sufficient.
- Start dropped and re-raised during WRITE has no effect. If start is high when DONE is reached, finished_bus holds until start falls.

## Structure
- Package ram_controller_pkg holds:
  - typedef enum logic [2:0] for modes: MODE_NOP=000, MODE_INIT=001, MODE_ZERO=010, MODE_ONES=011, MODE_DESC=100.
  - typedef enum for states IDLE/WRITE/DONE.
  - localparam DEPTH=256, localparam WIDTH=8.
- Optional sub-module ram_pattern_gen: a combinational function of (mode_q, i) returning the data byte. The FSM, counter and output registers live in ram_controller.

## Test plan
- Reset held for 15 cycles, start=0 → all outputs 0; after release, outputs stay 0 while start=0.
- mode=001, start raised and held → 256 consecutive cycles with wrenbus=1 and address=ram_in=0,1,…,255; then finished_bus=1, wrenbus=0.
- mode=001, start dropped after 170 write cycles and re-raised 20 cycles later → writes continue uninterrupted to 255; finished_bus=1 at cycle 257 and holds, because start is high.
- In DONE, start low for exactly one cycle then high → finished_bus falls; a second full 0..255 run follows, finishing 257 cycles after re-acceptance.
- mode=100 → ram_in=255-address for every write; mode=011 → all ram_in=FF; mode=110 → no writes, finished_bus=1 one cycle after acceptance.
- Reset asserted at write index 100 → next cycle wrenbus=0, address=0, finished_bus=0, state IDLE; a subsequent start restarts the run at address 0.

Source files
------------

// File: rtl/ram_controller_pkg.sv
// Shared types and constants for the RC4 state-array fill sequencer.
package ram_controller_pkg;

  localparam int DEPTH = 256;
  localparam int WIDTH = 8;

  typedef enum logic [2:0] {
    MODE_NOP  = 3'b000,
    MODE_INIT = 3'b001,
    MODE_ZERO = 3'b010,
    MODE_ONES = 3'b011,
    MODE_DESC = 3'b100
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Only the four defined patterns issue writes; every other code is a no-op.
  function automatic logic mode_writes(input logic [2:0] m);
    return (m == MODE_INIT) || (m == MODE_ZERO) || (m == MODE_ONES) || (m == MODE_DESC);
  endfunction

endpackage

// File: rtl/ram_controller_if.sv
// Request/response and RAM write-port signals between the decrypt FSM, this sequencer and the RAM.
interface ram_controller_if;
  import ram_controller_pkg::*;

  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] ram_in;
  logic             wrenbus;
  logic             finished_bus;

  modport master (
    output start, mode,
    input  address, ram_in, wrenbus, finished_bus
  );

  modport slave (
    input  start, mode,
    output address, ram_in, wrenbus, finished_bus
  );

endinterface

// File: rtl/ram_controller_pattern_gen.sv
// Combinational fill-pattern byte for a given mode and index.
module ram_pattern_gen
  import ram_controller_pkg::*;
(
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    case (mode)
      MODE_INIT: data = idx;
      MODE_ZERO: data = 8'h00;
      MODE_ONES: data = 8'hFF;
      MODE_DESC: data = 8'hFF - idx;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/ram_controller.sv
// Fills the 256x8 RAM with a mode-selected pattern, one write per clock, then
// holds finished_bus until the requester drops start.
//
// state | meaning
// IDLE  | outputs zero, waiting for start
// WRITE | presenting address i and its pattern, i = 0..255
// DONE  | finished_bus high, last address/data held until start is low
module ram_controller
  import ram_controller_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ram_controller_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wren_q, wren_d;
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] pattern;

  ram_pattern_gen u_pattern_gen (
    .mode (mode_q),
    .idx  (idx_q),
    .data (pattern)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    addr_d  = '0;
    data_d  = '0;
    wren_d  = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          idx_d   = '0;
          state_d = mode_writes(bus.mode) ? WRITE : DONE;
        end
      end
      WRITE: begin
        addr_d = idx_q;
        data_d = pattern;
        wren_d = 1'b1;
        // Counter stops at the last address; there is never a wrap write.
        if (idx_q == WIDTH'(DEPTH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      DONE: begin
        addr_d = addr_q;
        data_d = data_q;
        fin_d  = 1'b1;
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.address      = addr_q;
  assign bus.ram_in       = data_q;
  assign bus.wrenbus      = wren_q;
  assign bus.finished_bus = fin_q;

endmodule

// File: tb/tb_ram_controller.sv
// Directed bench for ram_controller: cycle model of the fill/handshake rules plus literal checkpoints.
module tb_ram_controller;

  logic clk;
  logic reset;

  ram_controller_if bus_if ();

  ram_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [2:0] m, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (m)
      3'd1:    return b;
      3'd2:    return 8'h00;
      3'd3:    return 8'hFF;
      3'd4:    return 8'd255 - b;
      default: return 8'h00;
    endcase
  endfunction

  // Model: counts edges since a request was accepted and derives outputs from that.
  bit         model_valid = 0;
  bit         run = 0;
  int         k = 0;
  int         nwr = 0;
  logic [2:0] mm = '0;
  logic [7:0] e_addr = '0, e_data = '0;
  logic       e_wr = 0, e_fin = 0;

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1;
      run = 0;
      e_addr = 0; e_data = 0; e_wr = 0; e_fin = 0;
    end else if (!run) begin
      e_addr = 0; e_data = 0; e_wr = 0; e_fin = 0;
      if (bus_if.start) begin
        run = 1;
        k   = 0;
        mm  = bus_if.mode;
        nwr = (mm >= 3'd1 && mm <= 3'd4) ? 256 : 0;
      end
    end else begin
      k++;
      if (k <= nwr) begin
        e_addr = 8'(k - 1);
        e_data = pat(mm, k - 1);
        e_wr   = 1;
        e_fin  = 0;
      end else begin
        e_wr  = 0;
        e_fin = 1;
        if (!bus_if.start) run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("address",      32'(bus_if.address),      32'(e_addr));
      chk("ram_in",       32'(bus_if.ram_in),       32'(e_data));
      chk("wrenbus",      32'(bus_if.wrenbus),      32'(e_wr));
      chk("finished_bus", 32'(bus_if.finished_bus), 32'(e_fin));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [7:0] a, input logic [7:0] d,
                     input logic w, input logic f);
    chk({name, ".address"},      32'(bus_if.address),      32'(a));
    chk({name, ".ram_in"},       32'(bus_if.ram_in),       32'(d));
    chk({name, ".wrenbus"},      32'(bus_if.wrenbus),      32'(w));
    chk({name, ".finished_bus"}, 32'(bus_if.finished_bus), 32'(f));
  endtask

  initial begin
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.mode  = 3'd0;
    tick(15);
    pin("reset_hold", 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick(5);
    pin("idle_after_reset", 8'h00, 8'h00, 1'b0, 1'b0);

    // Full INIT run with start held high.
    bus_if.mode = 3'd1; bus_if.start = 1'b1;
    tick(1);
    pin("init_accept", 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1);
    pin("init_first", 8'h00, 8'h00, 1'b1, 1'b0);
    tick(100);
    pin("init_mid", 8'd100, 8'd100, 1'b1, 1'b0);
    tick(155);
    pin("init_last", 8'hFF, 8'hFF, 1'b1, 1'b0);
    tick(1);
    pin("init_done", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick(5);
    bus_if.start = 1'b0;
    tick(1);
    pin("release_hold", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick(1);
    pin("release_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // Start dropped and re-raised mid-run: run continues, DONE holds.
    bus_if.start = 1'b1;
    tick(172);
    pin("drop_at_170", 8'd170, 8'd170, 1'b1, 1'b0);
    bus_if.start = 1'b0;
    tick(20);
    bus_if.start = 1'b1;
    tick(66);
    pin("drop_done", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick(10);
    pin("drop_done_hold", 8'hFF, 8'hFF, 1'b0, 1'b1);

    // One-cycle low pulse in DONE re-arms a second run; mode change mid-run ignored.
    bus_if.start = 1'b0;
    tick(1);
    bus_if.start = 1'b1;
    pin("pulse_low", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick(1);
    pin("pulse_fall", 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1);
    pin("rerun_first", 8'h00, 8'h00, 1'b1, 1'b0);
    tick(48);
    bus_if.mode = 3'd3;
    tick(208);
    pin("rerun_done", 8'hFF, 8'hFF, 1'b0, 1'b1);
    bus_if.start = 1'b0;
    tick(2);

    // Descending pattern.
    bus_if.mode = 3'd4; bus_if.start = 1'b1;
    tick(2);
    pin("desc_first", 8'h00, 8'hFF, 1'b1, 1'b0);
    tick(10);
    pin("desc_10", 8'd10, 8'd245, 1'b1, 1'b0);
    tick(246);
    pin("desc_done", 8'hFF, 8'h00, 1'b0, 1'b1);
    bus_if.start = 1'b0;
    tick(2);

    // All-ones pattern.
    bus_if.mode = 3'd3; bus_if.start = 1'b1;
    tick(2);
    pin("ones_first", 8'h00, 8'hFF, 1'b1, 1'b0);
    tick(256);
    pin("ones_done", 8'hFF, 8'hFF, 1'b0, 1'b1);
    bus_if.start = 1'b0;
    tick(2);

    // No-op mode: finished one cycle after acceptance, no writes.
    bus_if.mode = 3'd6; bus_if.start = 1'b1;
    tick(1);
    pin("nop_accept", 8'h00, 8'h00, 1'b0, 1'b0);
    tick(1);
    pin("nop_done", 8'h00, 8'h00, 1'b0, 1'b1);
    tick(3);
    bus_if.start = 1'b0;
    tick(2);

    // Reset at write index 100 aborts; restart begins at address 0.
    bus_if.mode = 3'd1; bus_if.start = 1'b1;
    tick(102);
    pin("abort_at_100", 8'd100, 8'd100, 1'b1, 1'b0);
    reset = 1'b1;
    tick(1);
    pin("abort_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick(2);
    pin("restart_first", 8'h00, 8'h00, 1'b1, 1'b0);
    tick(256);
    pin("restart_done", 8'hFF, 8'hFF, 1'b0, 1'b1);
    bus_if.start = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
